stream_rr_mux: RTL and testbench

- Parametrised N-to-1 stream multiplexer, the successor to the 4:1 combinational mux.
- Each input channel is a valid/ready/last stream. A round-robin arbiter picks the channel, and the mux forwards that channel's beats to one registered output stream.
- A grant locks onto a channel for a whole packet, from the first beat to the beat with last=1.
- Sits between several producer streams and one shared consumer.

---
 rtl/stream_rr_mux.sv | 123 ++++++++++++
 tb/tb_stream_rr_mux.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_mux.sv
// N-to-1 valid/ready/last stream mux with a round-robin arbiter that holds
// its grant for a whole packet and drives one registered output stream.
module stream_rr_mux #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  ptr, ptr_nxt;
  logic [SEL_W-1:0]  grant, grant_nxt;
  logic [SEL_W-1:0]  winner, src;
  logic              any_valid, can_load, take, beat_last;
  logic [DATA_W-1:0] beat_data;
  logic [DATA_W-1:0] ch_data [NUM_CH];

  logic [DATA_W-1:0] data_p1;
  logic              last_p1;
  logic [SEL_W-1:0]  sel_p1;
  logic              vld_p1;

  // Next channel index, wrapping NUM_CH-1 back to 0 for any NUM_CH.
  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
    return (idx == SEL_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_data[g] = in_data[g*DATA_W +: DATA_W];
  end

  // Round-robin search starting at ptr; the candidate index stays in 0..NUM_CH-1.
  always_comb begin
    logic [SEL_W:0]   cand;
    logic [SEL_W-1:0] cidx;
    any_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    cidx      = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      cand = {1'b0, ptr} + (SEL_W+1)'(j);
      if (cand >= (SEL_W+1)'(NUM_CH)) cand = cand - (SEL_W+1)'(NUM_CH);
      cidx = cand[SEL_W-1:0];
      if (!any_valid && in_valid[cidx]) begin
        any_valid = 1'b1;
        winner    = cidx;
      end
    end
  end

  always_comb begin
    can_load  = !vld_p1 || out_ready;
    src       = (state == LOCK) ? grant : winner;
    in_ready  = '0;
    if (!rst) begin
      if (state == IDLE) begin
        if (any_valid && can_load) in_ready[winner] = 1'b1;
      end else begin
        in_ready[grant] = can_load;
      end
    end
    take      = |(in_ready & in_valid);
    beat_last = in_last[src];
    beat_data = ch_data[src];

    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    if (take) begin
      if (beat_last) begin
        state_nxt = IDLE;
        ptr_nxt   = wrap_inc(src);
      end else begin
        state_nxt = LOCK;
        grant_nxt = src;
      end
    end
  end

  // Stage p1: output register; a drained slot may be refilled in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      grant   <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      sel_p1  <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      grant  <= grant_nxt;
      vld_p1 <= take || (vld_p1 && !out_ready);
      if (take) begin
        data_p1 <= beat_data;
        last_p1 <= beat_last;
        sel_p1  <= src;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_last  = last_p1;
  assign out_sel   = sel_p1;
  assign out_valid = vld_p1;
  assign busy      = (state == LOCK);

endmodule

// File: tb/tb_stream_rr_mux.sv
// Directed bench for stream_rr_mux: a 4-channel instance for the main cases
// and a 3-channel instance for pointer wrap on a non-power-of-2 count.
module tb_stream_rr_mux;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_last, in_ready;
  logic [7:0]  out_data;
  logic        out_last, out_valid, out_ready, busy;
  logic [1:0]  out_sel;

  logic [23:0] d3_in_data;
  logic [2:0]  d3_in_valid, d3_in_last, d3_in_ready;
  logic [7:0]  d3_out_data;
  logic        d3_out_last, d3_out_valid, d3_busy;
  logic [1:0]  d3_out_sel;

  int n_vec = 0;
  int n_err = 0;

  stream_rr_mux #(.NUM_CH(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_last(out_last), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  stream_rr_mux #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst), .in_data(d3_in_data), .in_valid(d3_in_valid),
    .in_last(d3_in_last), .in_ready(d3_in_ready), .out_data(d3_out_data),
    .out_last(d3_out_last), .out_sel(d3_out_sel), .out_valid(d3_out_valid),
    .out_ready(out_ready), .busy(d3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_d(input int ch, input logic [7:0] v);
    in_data[ch*8 +: 8] = v;
  endtask

  task automatic set_d3(input int ch, input logic [7:0] v);
    d3_in_data[ch*8 +: 8] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    in_data = '0; in_valid = 4'b0100; in_last = 4'b0100;
    d3_in_data = '0; d3_in_valid = '0; d3_in_last = 3'b111;
    set_d(2, 8'hA5);

    // Reset state, with ch2 already requesting.
    step(); step(); mid();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_sel", 32'(out_sel), 0);
    check("rst_busy", 32'(busy), 0);

    // Single beat from ch2.
    step(); rst = 1'b0;
    mid();  check("sb_in_ready", 32'(in_ready), 4);
    step(); in_valid = 4'b0000;
    mid();
    check("sb_out_valid", 32'(out_valid), 1);
    check("sb_out_data", 32'(out_data), 32'hA5);
    check("sb_out_sel", 32'(out_sel), 2);
    check("sb_out_last", 32'(out_last), 1);
    // ptr is now 3: ch3 beats ch0, then ch0 follows.
    step(); in_valid = 4'b1001; in_last = 4'b1001; set_d(0, 8'h30); set_d(3, 8'h33);
    mid();  check("ptr3_in_ready", 32'(in_ready), 8);
    step(); mid();
    check("ptr3_out_sel", 32'(out_sel), 3);
    check("ptr0_in_ready", 32'(in_ready), 1);
    step(); in_valid = 4'b0000;

    // Fairness with all channels streaming single-beat packets.
    do_reset();
    in_valid = 4'b1111; in_last = 4'b1111;
    for (int c = 0; c < 4; c++) set_d(c, 8'(8'h40 + c));
    for (int i = 0; i < 8; i++) begin
      step(); mid();
      check("fair_sel", 32'(out_sel), 32'(i % 4));
      check("fair_data", 32'(out_data), 32'(8'h40 + (i % 4)));
      check("fair_valid", 32'(out_valid), 1);
      check("fair_in_ready", 32'(in_ready), 32'(1 << ((i + 1) % 4)));
    end
    step(); in_valid = 4'b0000;

    // Packet lock on ch1 with ch0/ch3 also requesting.
    do_reset();
    in_valid = 4'b0001; in_last = 4'b0001; set_d(0, 8'h01);
    step();
    in_valid = 4'b1011; in_last = 4'b1001;
    set_d(0, 8'h02); set_d(1, 8'h11); set_d(3, 8'h33);
    mid();
    check("lk_first_data", 32'(out_data), 32'h01);
    check("lk_in_ready0", 32'(in_ready), 2);
    step(); set_d(1, 8'h12);
    mid();
    check("lk_data1", 32'(out_data), 32'h11);
    check("lk_sel1", 32'(out_sel), 1);
    check("lk_busy1", 32'(busy), 1);
    check("lk_in_ready1", 32'(in_ready), 2);
    step(); set_d(1, 8'h13); in_last = 4'b1011;
    mid();
    check("lk_data2", 32'(out_data), 32'h12);
    check("lk_busy2", 32'(busy), 1);
    step(); in_valid = 4'b1001; in_last = 4'b1001;
    mid();
    check("lk_data3", 32'(out_data), 32'h13);
    check("lk_last3", 32'(out_last), 1);
    check("lk_busy3", 32'(busy), 0);
    check("lk_next_grant", 32'(in_ready), 8);
    step(); in_valid = 4'b0100; in_last = 4'b0000; set_d(2, 8'h21);
    mid();
    check("lk_ch3_sel", 32'(out_sel), 3);
    check("lk_ch3_data", 32'(out_data), 32'h33);

    // Backpressure in the middle of a 4-beat ch2 packet.
    step(); set_d(2, 8'h22);
    mid();
    check("bp_data1", 32'(out_data), 32'h21);
    check("bp_busy", 32'(busy), 1);
    step(); set_d(2, 8'h23); out_ready = 1'b0;
    mid();
    check("bp_hold_data", 32'(out_data), 32'h22);
    check("bp_hold_in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 2; i++) begin
      step(); mid();
      check("bp_stall_data", 32'(out_data), 32'h22);
      check("bp_stall_in_ready", 32'(in_ready), 0);
      check("bp_stall_valid", 32'(out_valid), 1);
    end
    step(); out_ready = 1'b1;
    mid();
    check("bp_resume_in_ready", 32'(in_ready), 4);
    check("bp_resume_data", 32'(out_data), 32'h22);
    step(); set_d(2, 8'h24); in_last = 4'b0100;
    mid();
    check("bp_data3", 32'(out_data), 32'h23);
    check("bp_sel3", 32'(out_sel), 2);
    step(); in_valid = 4'b0000; in_last = 4'b0000;
    mid();
    check("bp_data4", 32'(out_data), 32'h24);
    check("bp_last4", 32'(out_last), 1);
    check("bp_busy4", 32'(busy), 0);
    step(); mid();
    check("bp_drain_valid", 32'(out_valid), 0);

    // Reset after 2 of 4 beats from ch1.
    in_valid = 4'b0010; set_d(1, 8'h51);
    step(); set_d(1, 8'h52);
    step(); rst = 1'b1;
    in_valid = 4'b0011; in_last = 4'b0001; set_d(0, 8'h60);
    mid();
    check("rm_in_ready_rst", 32'(in_ready), 0);
    step(); mid();
    check("rm_out_valid", 32'(out_valid), 0);
    check("rm_busy", 32'(busy), 0);
    check("rm_in_ready", 32'(in_ready), 0);
    step(); rst = 1'b0;
    mid();
    check("rm_regrant", 32'(in_ready), 1);
    step(); in_valid = 4'b0000; in_last = 4'b0000;
    mid();
    check("rm_out_data", 32'(out_data), 32'h60);
    check("rm_out_sel", 32'(out_sel), 0);

    // Three-channel instance: pointer wraps from 2 back to 0.
    d3_in_valid = 3'b010; set_d3(1, 8'h71);
    mid();
    check("w3_in_ready1", 32'(d3_in_ready), 2);
    step(); d3_in_valid = 3'b101; set_d3(0, 8'h70); set_d3(2, 8'h72);
    mid();
    check("w3_sel1", 32'(d3_out_sel), 1);
    check("w3_data1", 32'(d3_out_data), 32'h71);
    check("w3_in_ready2", 32'(d3_in_ready), 4);
    step(); mid();
    check("w3_sel2", 32'(d3_out_sel), 2);
    check("w3_data2", 32'(d3_out_data), 32'h72);
    check("w3_wrap_in_ready", 32'(d3_in_ready), 1);
    step(); d3_in_valid = 3'b000;
    mid();
    check("w3_sel0", 32'(d3_out_sel), 0);
    check("w3_data0", 32'(d3_out_data), 32'h70);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
